// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: the opcode map, the FSM state
// encoding and a width helper for the divider's iteration counter.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;
    localparam logic [2:0] OP_NOTX = 3'b110;
    localparam logic [2:0] OP_NOTY = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // The counter must hold the value N itself, so it needs one bit more than log2(N).
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand-issue / result-consumer bus of seq_alu.
// master (issuer/consumer side): drives in_valid, op, x, y, out_ready.
// slave  (seq_alu side): drives in_ready, out_valid, f, div_by_zero, zero, busy.
interface seq_alu_if #(parameter int N = 16);
    logic           in_valid;
    logic           in_ready;
    logic [2:0]     op;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] f;
    logic           div_by_zero;
    logic           zero;
    logic           busy;

    modport master (
        output in_valid, op, x, y, out_ready,
        input  in_ready, out_valid, f, div_by_zero, zero, busy
    );

    modport slave (
        input  in_valid, op, x, y, out_ready,
        output in_ready, out_valid, f, div_by_zero, zero, busy
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative signed divider: sign-magnitude restoring division, one quotient
// bit per cycle, N cycles per operation. y must be non-zero on start.
// Ports: clk, rst_n (async active-low); start with x/y operands;
// busy while iterating; done is high during the final iteration, together
// with the sign-corrected quot (toward zero) and rem (sign of x).
module seq_divider
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quot,
    output logic [N-1:0] rem
);
    localparam int CW = cnt_width(N);

    // a_q shifts dividend bits out at the top and quotient bits in at the bottom.
    logic [N-1:0]  a_q, a_d, r_q, r_d, d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, neg_q, neg_d, sx_q, sx_d;
    logic [N:0]    trial;
    logic          ge;
    logic [N-1:0]  a_step, r_step;

    always_comb begin
        trial  = {r_q, a_q[N-1]};
        ge     = trial >= {1'b0, d_q};
        // After a successful subtract the remainder is below the divisor, so N bits suffice.
        r_step = ge ? N'(trial - {1'b0, d_q}) : trial[N-1:0];
        a_step = {a_q[N-2:0], ge};

        a_d    = a_q;
        r_d    = r_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        neg_d  = neg_q;
        sx_d   = sx_q;

        if (start) begin
            // Magnitude of -2^(N-1) is 2^(N-1), which still fits unsigned N bits.
            a_d    = x[N-1] ? -x : x;
            d_d    = y[N-1] ? -y : y;
            r_d    = '0;
            cnt_d  = CW'(N);
            busy_d = 1'b1;
            neg_d  = x[N-1] ^ y[N-1];
            sx_d   = x[N-1];
        end else if (busy_q) begin
            a_d   = a_step;
            r_d   = r_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end

        done = busy_q && (cnt_q == CW'(1));
        quot = neg_q ? -a_step : a_step;
        rem  = sx_q ? -r_step : r_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
            sx_q   <= 1'b0;
        end else begin
            a_q    <= a_d;
            r_q    <= r_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            neg_q  <= neg_d;
            sx_q   <= sx_d;
        end
    end

    assign busy = busy_q;
endmodule

// File: rtl/seq_alu.sv
// Sequential signed ALU with valid/ready on both sides, registered 2N-bit
// result, iterative divider and status flags.
// Ports: clk, rst_n (async active-low); bus (seq_alu_if.slave) carrying the
// operand handshake (in_valid/in_ready, op, x, y), the result handshake
// (out_valid/out_ready, f) and the flags div_by_zero, zero, busy.
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | no result held, ready for an operation
// ST_BUSY | divider iterating
// ST_HOLD | result held in f until the consumer takes it
module seq_alu
    import alu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    state_e                state_q, state_d;
    logic [2*N-1:0]        f_q, f_d, alu_r;
    logic                  dbz_q, dbz_d, zero_q, zero_d, rdy_en_q;
    logic                  accept, div_start, load;
    logic                  div_busy, div_done;
    logic [N-1:0]          div_quot, div_rem, logic_r;
    logic signed [2*N-1:0] xs, ys;

    // rdy_en_q keeps in_ready low until the first clock edge after reset release.
    assign bus.in_ready = rdy_en_q &&
                          (state_q == ST_IDLE || (state_q == ST_HOLD && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign div_start    = accept && (bus.op == OP_DIV) && (bus.y != '0);

    always_comb begin
        xs      = {{N{bus.x[N-1]}}, bus.x};
        ys      = {{N{bus.y[N-1]}}, bus.y};
        logic_r = '0;
        alu_r   = '0;
        case (bus.op)
            OP_ADD:  alu_r = xs + ys;
            OP_SUB:  alu_r = xs - ys;
            OP_MUL:  alu_r = xs * ys;
            OP_DIV:  alu_r = {{N{1'b1}}, bus.x};   // only reaches f when y == 0
            OP_OR:   logic_r = bus.x | bus.y;
            OP_AND:  logic_r = bus.x & bus.y;
            OP_NOTX: logic_r = ~bus.x;
            OP_NOTY: logic_r = ~bus.y;
            default: alu_r = '0;
        endcase
        // Opcodes 1xx are the bitwise group, sign-extended from N bits.
        if (bus.op[2]) begin
            alu_r = {{N{logic_r[N-1]}}, logic_r};
        end
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        dbz_d   = dbz_q;
        load    = 1'b0;
        if (accept) begin
            if (div_start) begin
                state_d = ST_BUSY;
            end else begin
                state_d = ST_HOLD;
                f_d     = alu_r;
                dbz_d   = (bus.op == OP_DIV);
                load    = 1'b1;
            end
        end else begin
            case (state_q)
                ST_BUSY: if (div_done) begin
                    state_d = ST_HOLD;
                    f_d     = {div_quot, div_rem};
                    dbz_d   = 1'b0;
                    load    = 1'b1;
                end
                ST_HOLD: if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
                default: state_d = state_q;
            endcase
        end
        zero_d = load ? (f_d == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            f_q      <= '0;
            dbz_q    <= 1'b0;
            zero_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            f_q      <= f_d;
            dbz_q    <= dbz_d;
            zero_q   <= zero_d;
            rdy_en_q <= 1'b1;
        end
    end

    seq_divider #(.N(N)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .x     (bus.x),
        .y     (bus.y),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot),
        .rem   (div_rem)
    );

    assign bus.out_valid   = (state_q == ST_HOLD);
    assign bus.f           = f_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.zero        = zero_q;
    assign bus.busy        = div_busy;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed cases plus random operations against an
// arithmetic reference model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    seq_alu_if #(.N(N)) bus();

    seq_alu #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] actv, input logic [63:0] expv);
        n_chk++;
        if (actv !== expv) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, actv, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the signed operand values.
    function automatic logic [31:0] ref_f(input logic [2:0] op, input logic [15:0] x,
                                          input logic [15:0] y);
        int sx, sy, q, m, r;
        logic [31:0] rv, qv, mv, r32;
        sx = $signed(x);
        sy = $signed(y);
        rv = '0;
        r  = 0;
        case (op)
            OP_ADD: rv = sx + sy;
            OP_SUB: rv = sx - sy;
            OP_MUL: rv = sx * sy;
            OP_DIV: begin
                if (sy == 0) begin
                    rv = {16'hFFFF, x};
                end else begin
                    q  = sx / sy;
                    m  = sx % sy;
                    qv = q;
                    mv = m;
                    rv = {qv[15:0], mv[15:0]};
                end
            end
            OP_OR:   begin r = $signed(x | y); r32 = r; rv = r32; end
            OP_AND:  begin r = $signed(x & y); r32 = r; rv = r32; end
            OP_NOTX: begin r = $signed(~x);    r32 = r; rv = r32; end
            default: begin r = $signed(~y);    r32 = r; rv = r32; end
        endcase
        return rv;
    endfunction

    // One isolated operation from IDLE: accept, latency, result, flags,
    // stability under back-pressure, then consumption back to IDLE.
    task automatic run_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                          input int stall, input string tag);
        logic [31:0] exp_f;
        int exp_lat, lat;
        bit got;
        exp_f   = ref_f(op, x, y);
        exp_lat = (op == OP_DIV && y != 16'h0) ? N + 1 : 1;
        @(negedge clk);
        bus.op = op; bus.x = x; bus.y = y;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.in_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            chk({tag, "_accept_timeout"}, 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op = 3'($urandom);
        bus.x  = 16'($urandom);
        bus.y  = 16'($urandom);
        @(negedge clk);
        lat = 1;
        if (exp_lat > 1) begin
            chk({tag, "_busy"}, 64'(bus.busy), 1);
            chk({tag, "_rdy_busy"}, 64'(bus.in_ready), 0);
        end
        while (!bus.out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_f"}, 64'(bus.f), 64'(exp_f));
        chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(op == OP_DIV && y == 16'h0));
        chk({tag, "_zero"}, 64'(bus.zero), 64'(exp_f == 32'h0));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk({tag, "_hold_f"}, 64'(bus.f), 64'(exp_f));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_drain"}, 64'(bus.out_valid), 0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op = OP_ADD;
        bus.x = '0;
        bus.y = '0;

        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_f", 64'(bus.f), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_in_ready", 64'(bus.in_ready), 0);
        chk("rst_zero", 64'(bus.zero), 0);
        chk("rst_dbz", 64'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", 64'(bus.in_ready), 0);
        @(negedge clk);
        chk("rdy_after_edge", 64'(bus.in_ready), 1);

        run_op(OP_ADD, 16'd100, -16'sd30, 0, "add");
        run_op(OP_DIV, 16'd100, 16'd7, 2, "div_100_7");
        run_op(OP_DIV, -16'sd7, 16'd2, 0, "div_m7_2");
        run_op(OP_DIV, 16'd5, 16'd0, 1, "div_by0");
        run_op(OP_DIV, 16'h8000, 16'hFFFF, 0, "div_wrap");

        // Back-to-back SUB then OR with the consumer always ready.
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.op = OP_SUB; bus.x = 16'd5; bus.y = 16'd5;
        @(negedge clk);
        chk("b2b_sub_valid", 64'(bus.out_valid), 1);
        chk("b2b_sub_f", 64'(bus.f), 0);
        chk("b2b_sub_zero", 64'(bus.zero), 1);
        chk("b2b_rdy", 64'(bus.in_ready), 1);
        bus.op = OP_OR; bus.x = 16'h00F0; bus.y = 16'h0F00;
        @(negedge clk);
        chk("b2b_or_valid", 64'(bus.out_valid), 1);
        chk("b2b_or_f", 64'(bus.f), 64'h0000_0FF0);
        chk("b2b_or_zero", 64'(bus.zero), 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_drain", 64'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // MUL held under back-pressure, then consume and accept in the same cycle.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = OP_MUL; bus.x = -16'sd3; bus.y = 16'd4;
        @(negedge clk);
        bus.op = OP_NOTX; bus.x = 16'h0; bus.y = 16'($urandom);
        for (int s = 0; s < 5; s++) begin
            chk("mul_hold_f", 64'(bus.f), 64'hFFFF_FFF4);
            chk("mul_hold_rdy", 64'(bus.in_ready), 0);
            chk("mul_hold_valid", 64'(bus.out_valid), 1);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("notx_valid", 64'(bus.out_valid), 1);
        chk("notx_f", 64'(bus.f), 64'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("notx_drain", 64'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // Reset in the middle of a division.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = OP_DIV; bus.x = 16'd1000; bus.y = 16'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("mid_div_busy", 64'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(bus.out_valid), 0);
        chk("abort_busy", 64'(bus.busy), 0);
        chk("abort_rdy", 64'(bus.in_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_before_edge", 64'(bus.in_ready), 0);
        @(negedge clk);
        chk("rel_rdy", 64'(bus.in_ready), 1);
        seen = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chk("no_stale_result", 64'(seen), 0);
        run_op(OP_ADD, 16'd1, 16'd1, 0, "post_rst_add");

        // Random operations.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rop;
            logic [15:0] rx, ry;
            rop = 3'($urandom);
            rx  = 16'($urandom);
            ry  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rx = 16'h8000;
                ry = 16'hFFFF;
            end
            run_op(rop, rx, ry, $urandom_range(0, 3), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
